updown_counter8: RTL and testbench
==================================

// Module: updown_counter8
// PURPOSE
//   Downstream consumer of the 4:1 clock-select mux. Counts rising edges of the
//   selected rate signal (tick_in, a slow derived clock) in the system clk domain.
//   Synchronizes tick_in and the up/down switch, then keeps an 8-bit up/down count
//   with load, enable and wrap/saturate modes. Drives the board LEDs/display.
// PARAMETERS
//   WIDTH        8   counter width in bits
//   SYNC_STAGES  2   flops in the tick_in and up_dn synchronizers (>=2)
// PORTS
//   clk       in   1      system clock; all state updates on its rising edge
//   rst_n     in   1      synchronous reset, active-low
//   tick_in   in   1      selected rate clock from the mux; async to clk
//   up_dn     in   1      direction switch: 1 = up, 0 = down; async
//   en        in   1      count enable; sync to clk
//   load      in   1      synchronous load strobe; sync to clk
//   load_val  in   WIDTH  value taken by load
//   sat_mode  in   1      0 = wrap at bounds, 1 = saturate at bounds
//   count     out  WIDTH  current count
//   tc        out  1      terminal-count pulse, one clk cycle
//   dir_o     out  1      synchronized direction in use
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): count=0, tc=0, dir_o=1. tick_in sync stages and
//     edge-delay flop reset to 1, so tick_in held high across reset release is not
//     counted. up_dn sync stages reset to 1. Reset overrides every other input.
//   tick_in: passes through SYNC_STAGES flops (tick_s); tick_d = tick_s delayed one
//     cycle; tick_evt = tick_s & ~tick_d. Only rising edges count; tick_evt lasts
//     exactly one clk cycle per tick_in rising edge.
//   Latency: tick_in rising before clk edge N gives a count change at edge
//     N+SYNC_STAGES (visible after edge N+2 with the default).
//   up_dn: passes through SYNC_STAGES flops; dir_o = synchronized value. Direction
//     is sampled at each counted event; a switch flip never causes a count.
//   Priority per clk edge: load > (en & tick_evt) > hold.
//     load=1: count <= load_val, tc <= 0. Coincident tick_evt is dropped.
//     en=0: count holds. The edge detector keeps tracking, so ticks are not queued.
//   Counted event (en & tick_evt & ~load):
//     up,   count<MAX: count+1     | up,   count==MAX: wrap->0 / sat->hold MAX
//     down, count>0:   count-1     | down, count==0:   wrap->MAX / sat->hold 0
//     MAX = 2**WIDTH-1. All arithmetic is modulo 2**WIDTH.
//   tc: 1 for the cycle after every counted event taken at a bound (up at MAX,
//     down at 0), in both modes. 0 in all other cycles. In sat mode it pulses on
//     each further event at the bound.
//   sat_mode change: takes effect on the next event. An in-range count is unaffected.
//   Mid-operation reset: the count is lost. No tick is counted until tick_in shows
//     a fresh rising edge after rst_n returns high.
//   tick_in is assumed slower than clk/4. Faster edges can be merged; no other
//     guarantee applies.
// TESTING
//   1 Reset release with tick_in=1, then 3 tick_in rising edges, up, en=1
//     -> count=3, 0->1->2->3. Each step lands 2 clk edges after its tick.
//   2 load_val=8'hFE, load, up, wrap, 3 ticks -> count FF, 00, 01.
//     tc pulses once, on the FF->00 event.
//   3 load 8'h01, down, sat_mode=1, 3 ticks -> count 00, 00, 00.
//     tc pulses on the 2nd and 3rd events.
//   4 load and tick_evt in the same cycle, load_val=8'h40 -> count=8'h40, tc=0.
//     Next tick gives 8'h41.
//   5 en=0 during 4 ticks, then en=1 for 1 tick -> count +1 only, no backlog.
//   6 count=8'h10, rst_n low 1 cycle mid-stream -> count=0, dir_o=1, tc=0.
//     Counting resumes on the next fresh rising edge.

Source files
------------

// File: rtl/updown_counter8.sv
// 8-bit up/down event counter clocked by clk, counting rising edges of an
// asynchronous slow tick. Direction and tick are synchronized; supports load,
// enable and wrap/saturate behaviour at the bounds with a terminal-count pulse.
module updown_counter8 #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             up_dn,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             dir_o
);

    localparam logic [WIDTH-1:0] MaxCount = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] One      = WIDTH'(1);

    logic [SYNC_STAGES-1:0] tick_sync_q;
    logic [SYNC_STAGES-1:0] dir_sync_q;
    logic                   tick_d_q;
    logic                   tick_s;
    logic                   tick_evt;
    logic                   dir_s;

    logic [WIDTH-1:0]       count_q;
    logic [WIDTH-1:0]       count_d;
    logic                   tc_q;
    logic                   tc_d;

    assign tick_s   = tick_sync_q[SYNC_STAGES-1];
    assign dir_s    = dir_sync_q[SYNC_STAGES-1];
    assign tick_evt = tick_s & ~tick_d_q;

    // Synchronizers and edge-delay flop; preset to 1 so a tick_in held high
    // across reset release does not look like a rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_sync_q <= '1;
            dir_sync_q  <= '1;
            tick_d_q    <= 1'b1;
        end else begin
            tick_sync_q <= {tick_sync_q[SYNC_STAGES-2:0], tick_in};
            dir_sync_q  <= {dir_sync_q[SYNC_STAGES-2:0], up_dn};
            tick_d_q    <= tick_s;
        end
    end

    // Next count: load wins over a counted event; tc flags events taken at a bound.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en && tick_evt) begin
            if (dir_s) begin
                if (count_q == MaxCount) begin
                    tc_d    = 1'b1;
                    count_d = sat_mode ? MaxCount : '0;
                end else begin
                    count_d = count_q + One;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = sat_mode ? '0 : MaxCount;
                end else begin
                    count_d = count_q - One;
                end
            end
        end
    end

    // Count and terminal-count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign dir_o = dir_s;

endmodule

// File: tb/tb_updown_counter8.sv
// Scoreboard bench for updown_counter8: each driven tick pushes the expected
// {count, tc} from a bench-side reference model; tests pop and compare inline.
module tb_updown_counter8;

    logic       clk;
    logic       rst_n;
    logic       tick_in;
    logic       up_dn;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic       sat_mode;
    logic [7:0] count;
    logic       tc;
    logic       dir_o;

    typedef struct packed {
        logic [7:0] cnt;
        logic       tcv;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_count;
    int         n_pass;
    int         n_total;

    updown_counter8 #(
        .WIDTH      (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_in (tick_in),
        .up_dn   (up_dn),
        .en      (en),
        .load    (load),
        .load_val(load_val),
        .sat_mode(sat_mode),
        .count   (count),
        .tc      (tc),
        .dir_o   (dir_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour of one counted event.
    function automatic void ref_step(input logic [7:0] cur, input logic up, input logic sat,
                                     output logic [7:0] nxt, output logic tcv);
        tcv = 1'b0;
        if (up) begin
            if (cur == 8'hFF) begin
                tcv = 1'b1;
                nxt = sat ? 8'hFF : 8'h00;
            end else begin
                nxt = cur + 8'd1;
            end
        end else begin
            if (cur == 8'h00) begin
                tcv = 1'b1;
                nxt = sat ? 8'h00 : 8'hFF;
            end else begin
                nxt = cur - 8'd1;
            end
        end
    endfunction

    // Raise tick_in before edge N, push the expectation, return just after edge N+1.
    task automatic tick_rise();
        exp_t       e;
        logic [7:0] nxt;
        logic       t;
        @(negedge clk);
        tick_in = 1'b1;
        if (en) begin
            ref_step(m_count, up_dn, sat_mode, nxt, t);
        end else begin
            nxt = m_count;
            t   = 1'b0;
        end
        e.cnt   = nxt;
        e.tcv   = t;
        sb.push_back(e);
        m_count = nxt;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    // Edge N+2: the counted event becomes visible.
    task automatic tick_land();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_fall();
        @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_dir(input logic d);
        @(negedge clk);
        up_dn = d;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        load_val = v;
        load     = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        m_count = v;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        tick_in  = 1'b1;
        up_dn    = 1'b1;
        en       = 1'b1;
        load     = 1'b0;
        load_val = 8'h00;
        sat_mode = 1'b0;
        m_count  = 8'h00;
        repeat (3) @(negedge clk);
        n_total++;
        if (count !== 8'h00 || tc !== 1'b0 || dir_o !== 1'b1)
            $display("FAIL reset_state: count=%h tc=%b dir=%b, want 00 0 1", count, tc, dir_o);
        else n_pass++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_total++;
        if (count !== 8'h00)
            $display("FAIL reset_high_tick: count=%h, want 00", count);
        else n_pass++;
        tick_fall();
    endtask

    task automatic test_count_up();
        exp_t       e;
        logic [7:0] old;
        for (int i = 0; i < 3; i++) begin
            old = m_count;
            tick_rise();
            n_total++;
            if (count !== old) $display("FAIL latency_%0d: count=%h, want %h", i, count, old);
            else n_pass++;
            tick_land();
            e = sb.pop_front();
            n_total++;
            if (count !== e.cnt || tc !== e.tcv)
                $display("FAIL up_%0d: count=%h tc=%b, want %h %b", i, count, tc, e.cnt, e.tcv);
            else n_pass++;
            tick_fall();
        end
        n_total++;
        if (count !== 8'h03) $display("FAIL up_final: count=%h, want 03", count);
        else n_pass++;
    endtask

    task automatic test_wrap_up();
        exp_t e;
        sat_mode = 1'b0;
        do_load(8'hFE);
        n_total++;
        if (count !== 8'hFE || tc !== 1'b0)
            $display("FAIL load_fe: count=%h tc=%b, want fe 0", count, tc);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick_rise();
            tick_land();
            e = sb.pop_front();
            n_total++;
            if (count !== e.cnt || tc !== e.tcv)
                $display("FAIL wrap_%0d: count=%h tc=%b, want %h %b", i, count, tc, e.cnt, e.tcv);
            else n_pass++;
            tick_fall();
            n_total++;
            if (tc !== 1'b0) $display("FAIL wrap_tc_clear_%0d: tc=%b, want 0", i, tc);
            else n_pass++;
        end
    endtask

    task automatic test_sat_down();
        exp_t e;
        sat_mode = 1'b1;
        set_dir(1'b0);
        n_total++;
        if (dir_o !== 1'b0) $display("FAIL dir_down: dir=%b, want 0", dir_o);
        else n_pass++;
        do_load(8'h01);
        for (int i = 0; i < 3; i++) begin
            tick_rise();
            tick_land();
            e = sb.pop_front();
            n_total++;
            if (count !== e.cnt || tc !== e.tcv)
                $display("FAIL sat_%0d: count=%h tc=%b, want %h %b", i, count, tc, e.cnt, e.tcv);
            else n_pass++;
            tick_fall();
        end
        sat_mode = 1'b0;
        set_dir(1'b1);
    endtask

    task automatic test_load_collision();
        exp_t e;
        @(negedge clk);
        tick_in = 1'b1;
        e.cnt   = 8'h40;
        e.tcv   = 1'b0;
        sb.push_back(e);
        m_count = 8'h40;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        load_val = 8'h40;
        load     = 1'b1;
        tick_land();
        e = sb.pop_front();
        n_total++;
        if (count !== e.cnt || tc !== e.tcv)
            $display("FAIL load_vs_tick: count=%h tc=%b, want %h %b", count, tc, e.cnt, e.tcv);
        else n_pass++;
        @(negedge clk);
        load = 1'b0;
        tick_fall();
        tick_rise();
        tick_land();
        e = sb.pop_front();
        n_total++;
        if (count !== e.cnt) $display("FAIL after_load: count=%h, want %h", count, e.cnt);
        else n_pass++;
        tick_fall();
    endtask

    task automatic test_enable();
        exp_t e;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick_rise();
            tick_land();
            e = sb.pop_front();
            n_total++;
            if (count !== e.cnt || tc !== e.tcv)
                $display("FAIL en_off_%0d: count=%h tc=%b, want %h %b", i, count, tc, e.cnt, e.tcv);
            else n_pass++;
            tick_fall();
        end
        en = 1'b1;
        tick_rise();
        tick_land();
        e = sb.pop_front();
        n_total++;
        if (count !== e.cnt) $display("FAIL en_resume: count=%h, want %h", count, e.cnt);
        else n_pass++;
        tick_fall();
        repeat (6) @(negedge clk);
        n_total++;
        if (count !== e.cnt) $display("FAIL no_backlog: count=%h, want %h", count, e.cnt);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        exp_t e;
        do_load(8'h10);
        set_dir(1'b0);
        @(negedge clk);
        tick_in = 1'b1;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_count = 8'h00;
        n_total++;
        if (count !== 8'h00 || tc !== 1'b0 || dir_o !== 1'b1)
            $display("FAIL mid_reset: count=%h tc=%b dir=%b, want 00 0 1", count, tc, dir_o);
        else n_pass++;
        up_dn = 1'b1;
        repeat (5) @(negedge clk);
        n_total++;
        if (count !== 8'h00) $display("FAIL stale_tick: count=%h, want 00", count);
        else n_pass++;
        tick_fall();
        tick_rise();
        tick_land();
        e = sb.pop_front();
        n_total++;
        if (count !== e.cnt || tc !== e.tcv)
            $display("FAIL resume: count=%h tc=%b, want %h %b", count, tc, e.cnt, e.tcv);
        else n_pass++;
        tick_fall();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_count_up();
        test_wrap_up();
        test_sat_down();
        test_load_collision();
        test_enable();
        test_mid_reset();
        n_total++;
        if (sb.size() != 0) $display("FAIL scoreboard_leftover: size=%0d, want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
